// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin owner of one shared WIDTH-bit down-counter.
// Requesters hold req high with a duration. The winner is latched and the
// counter runs. Completion is a single-cycle done pulse to the owner. All
// state advances on the falling edge of clk.
module timer_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 4,
  localparam int IDXW  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] dur,
  output logic [N_REQ-1:0]       grant,
  output logic [IDXW-1:0]        owner,
  output logic                   busy,
  output logic [WIDTH-1:0]       count,
  output logic [N_REQ-1:0]       done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q;
  logic [IDXW-1:0]   ptr_q;
  logic [N_REQ-1:0]  grant_q;
  logic [IDXW-1:0]   owner_q;
  logic              busy_q;
  logic [WIDTH-1:0]  count_q;
  logic [N_REQ-1:0]  done_q;

  // Per-requester duration view, so the winner's value is a plain array pick.
  logic [WIDTH-1:0] dur_a [N_REQ];
  for (genvar i = 0; i < N_REQ; i++) begin : g_dur
    assign dur_a[i] = dur[i*WIDTH +: WIDTH];
  end

  // Round-robin search starting at ptr_q. The loop runs backwards so that the
  // closest asserted request to the pointer is the last one written.
  logic             found;
  logic [IDXW-1:0]  win;
  logic [IDXW-1:0]  cand;
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IDXW'((int'(ptr_q) + k) % N_REQ);
      if (req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // One-hot form of the winner, loaded straight into grant.
  logic [N_REQ-1:0] win_oh;
  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  // Pointer moves one past the finishing owner, wrapping for any N_REQ.
  logic [IDXW-1:0] ptr_nxt;
  assign ptr_nxt = (owner_q == IDXW'(N_REQ - 1)) ? '0 : owner_q + IDXW'(1);

  // Arbitration / countdown FSM; all outputs come straight from registers.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      done_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= '0;
          if (found) begin
            state_q <= RUN;
            grant_q <= win_oh;
            owner_q <= win;
            busy_q  <= 1'b1;
            count_q <= dur_a[win];
          end else begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
          end
        end
        RUN: begin
          if (!req[owner_q]) begin
            // Abort wins over terminal count: no done pulse.
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            ptr_q   <= ptr_nxt;
          end else if (count_q == '0) begin
            state_q <= DONE;
            done_q  <= grant_q;
          end else begin
            count_q <= count_q - WIDTH'(1);
          end
        end
        DONE: begin
          // Exactly one cycle here whatever req does.
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          count_q <= '0;
          done_q  <= '0;
          ptr_q   <= ptr_nxt;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          count_q <= '0;
          done_q  <= '0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign count = count_q;
  assign done  = done_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: directed per-cycle vectors push the expected
// post-edge outputs into a queue; a monitor pops and compares once per cycle
// on the rising edge, away from the falling active edge.
module tb_timer_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] dur;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        busy;
  logic [3:0]  count;
  logic [3:0]  done;

  timer_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .req(req), .dur(dur),
    .grant(grant), .owner(owner), .busy(busy), .count(count), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] o;
    logic       b;
    logic [3:0] c;
    logic [3:0] d;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(posedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cyc++;
      chk("grant", {4'h0, grant}, {4'h0, e.g});
      chk("owner", {6'h0, owner}, {6'h0, e.o});
      chk("busy",  {7'h0, busy},  {7'h0, e.b});
      chk("count", {4'h0, count}, {4'h0, e.c});
      chk("done",  {4'h0, done},  {4'h0, e.d});
    end
  end

  // Apply inputs for the next falling edge and queue the outputs it must give.
  task automatic step(input logic rst, input logic [3:0] r, input logic [15:0] d,
                      input logic [3:0] eg, input logic [1:0] eo, input logic eb,
                      input logic [3:0] ec, input logic [3:0] ed);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    req   = r;
    dur   = d;
    e.g = eg; e.o = eo; e.b = eb; e.c = ec; e.d = ed;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] w;
    logic [3:0] g;
    reset = 1'b1; req = '0; dur = '0;

    // Reset state
    step(1, 4'b0000, 16'h0000, 4'b0000, 0, 0, 0, 4'b0000);
    step(1, 4'b0000, 16'h0000, 4'b0000, 0, 0, 0, 4'b0000);
    step(0, 4'b0000, 16'h0000, 4'b0000, 0, 0, 0, 4'b0000);

    // Single request, dur0=3: count 3,2,1,0,0 then done, then idle
    step(0, 4'b0001, 16'h0003, 4'b0001, 0, 1, 3, 4'b0000);
    step(0, 4'b0001, 16'h0003, 4'b0001, 0, 1, 2, 4'b0000);
    step(0, 4'b0001, 16'h0003, 4'b0001, 0, 1, 1, 4'b0000);
    step(0, 4'b0001, 16'h0003, 4'b0001, 0, 1, 0, 4'b0000);
    step(0, 4'b0001, 16'h0003, 4'b0001, 0, 1, 0, 4'b0001);
    step(0, 4'b0000, 16'h0003, 4'b0000, 0, 0, 0, 4'b0000);
    step(0, 4'b0000, 16'h0000, 4'b0000, 0, 0, 0, 4'b0000);

    // Round-robin from reset, all dur=1: owners 0,1,2,3,0
    step(1, 4'b0000, 16'h0000, 4'b0000, 0, 0, 0, 4'b0000);
    for (int n = 0; n < 5; n++) begin
      w = 2'(n % 4);
      g = 4'b0001 << w;
      step(0, 4'b1111, 16'h1111, g,       w, 1, 1, 4'b0000);
      step(0, 4'b1111, 16'h1111, g,       w, 1, 0, 4'b0000);
      step(0, 4'b1111, 16'h1111, g,       w, 1, 0, g);
      step(0, 4'b1111, 16'h1111, 4'b0000, w, 0, 0, 4'b0000);
    end

    // Zero duration on requester 3, then ptr wraps so 0 beats 3
    step(0, 4'b1000, 16'h0000, 4'b1000, 3, 1, 0, 4'b0000);
    step(0, 4'b1000, 16'h0000, 4'b1000, 3, 1, 0, 4'b1000);
    step(0, 4'b1001, 16'h0002, 4'b0000, 3, 0, 0, 4'b0000);
    step(0, 4'b1001, 16'h0002, 4'b0001, 0, 1, 2, 4'b0000);
    step(0, 4'b0000, 16'h0000, 4'b0000, 0, 0, 0, 4'b0000);

    // Abort: owner 1 with dur 9 drops at count 6, pending req2 follows
    step(0, 4'b0110, 16'h0490, 4'b0010, 1, 1, 9, 4'b0000);
    step(0, 4'b0110, 16'h0490, 4'b0010, 1, 1, 8, 4'b0000);
    step(0, 4'b0110, 16'h0490, 4'b0010, 1, 1, 7, 4'b0000);
    step(0, 4'b0110, 16'h0490, 4'b0010, 1, 1, 6, 4'b0000);
    step(0, 4'b0100, 16'h0490, 4'b0000, 1, 0, 0, 4'b0000);
    step(0, 4'b0100, 16'h0490, 4'b0100, 2, 1, 4, 4'b0000);

    // dur changes after grant are ignored; abort collides with count==0
    step(0, 4'b0100, 16'h0F00, 4'b0100, 2, 1, 3, 4'b0000);
    step(0, 4'b0100, 16'h0F00, 4'b0100, 2, 1, 2, 4'b0000);
    step(0, 4'b0100, 16'h0F00, 4'b0100, 2, 1, 1, 4'b0000);
    step(0, 4'b0100, 16'h0F00, 4'b0100, 2, 1, 0, 4'b0000);
    step(0, 4'b0000, 16'h0F00, 4'b0000, 2, 0, 0, 4'b0000);

    // Reset mid-run at count 5 (ptr=3 before reset), then owner 0 first
    step(0, 4'b0100, 16'h0700, 4'b0100, 2, 1, 7, 4'b0000);
    step(0, 4'b0100, 16'h0700, 4'b0100, 2, 1, 6, 4'b0000);
    step(0, 4'b0100, 16'h0700, 4'b0100, 2, 1, 5, 4'b0000);
    step(1, 4'b1111, 16'h7777, 4'b0000, 0, 0, 0, 4'b0000);
    step(0, 4'b1111, 16'h7777, 4'b0001, 0, 1, 7, 4'b0000);
    step(0, 4'b1111, 16'h7777, 4'b0001, 0, 1, 6, 4'b0000);

    @(posedge clk);
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
